// File: rtl/imem_load_ctrl_pkg.sv
// ============================================================================
// imem_load_ctrl_pkg : shared constants for the instruction-memory loader
// Revision: 1.0
// ============================================================================
`default_nettype none

package imem_load_ctrl_pkg;

   localparam int c_rom_aw = 14;

   localparam logic [1:0] c_st_run   = 2'd0;
   localparam logic [1:0] c_st_arm   = 2'd1;
   localparam logic [1:0] c_st_load  = 2'd2;
   localparam logic [1:0] c_st_flush = 2'd3;

   localparam int                c_flush_len  = 2;
   localparam int                c_flush_cw   = 1;
   localparam logic [c_flush_cw-1:0] c_flush_last = c_flush_cw'(c_flush_len - 1);

   localparam logic [c_rom_aw-1:0] c_word_count_max = {c_rom_aw{1'b1}};

endpackage

`default_nettype wire

// File: rtl/imem_load_ctrl.sv
// ============================================================================
// imem_load_ctrl : arbitrates the program ROM port between CPU fetch and the
//                  UART programmer. Optional macro: IMEM_LOAD_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_load_ctrl
   import imem_load_ctrl_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                load_req,
   input  logic                upg_wen_i,
   input  logic [14:0]         upg_adr_i,
   input  logic [31:0]         upg_dat_i,
   input  logic                upg_done_i,
   input  logic [c_rom_aw-1:0] fetch_addr,
   output logic [31:0]         fetch_dout,
   output logic                rom_wea,
   output logic [c_rom_aw-1:0] rom_addra,
   output logic [31:0]         rom_dina,
   input  logic [31:0]         rom_douta,
   output logic                cpu_stall,
   output logic                cpu_rst_o,
   output logic                upg_rst_o,
   output logic [c_rom_aw-1:0] word_count,
   output logic                load_err,
   output logic [31:0]         checksum
);

   logic [1:0]            state_q, state_d;
   logic [c_rom_aw-1:0]   word_count_q, word_count_d;
   logic                  load_err_q, load_err_d;
   logic [c_flush_cw-1:0] flush_cnt_q, flush_cnt_d;
   logic                  wr_accept;

   always_comb begin
      state_d      = state_q;
      word_count_d = word_count_q;
      load_err_d   = load_err_q;
      flush_cnt_d  = flush_cnt_q;
      wr_accept    = 1'b0;
      rom_addra    = fetch_addr;
      rom_dina     = '0;
      rom_wea      = 1'b0;
      fetch_dout   = rom_douta;
      cpu_stall    = 1'b1;
      cpu_rst_o    = 1'b0;
      upg_rst_o    = 1'b1;
      case (state_q)
         c_st_run: begin
            cpu_stall = 1'b0;
            if (load_req) begin
               state_d      = c_st_arm;
               word_count_d = '0;
               load_err_d   = 1'b0;
            end
         end
         // ARM keeps the fetch path live so the in-flight read completes.
         c_st_arm: begin
            upg_rst_o = 1'b0;
            state_d   = c_st_load;
         end
         c_st_load: begin
            upg_rst_o  = 1'b0;
            fetch_dout = '0;
            rom_addra  = upg_adr_i[c_rom_aw-1:0];
            rom_dina   = upg_dat_i;
            wr_accept  = upg_wen_i & ~upg_adr_i[14];
            rom_wea    = wr_accept;
            if (wr_accept && (word_count_q != c_word_count_max)) begin
               word_count_d = word_count_q + c_rom_aw'(1);
            end
            if (upg_done_i) begin
               state_d     = c_st_flush;
               flush_cnt_d = '0;
               if (word_count_d == '0) begin
                  load_err_d = 1'b1;
               end
            end
         end
         c_st_flush: begin
            fetch_dout = '0;
            cpu_rst_o  = (flush_cnt_q == c_flush_last);
            if (flush_cnt_q == c_flush_last) begin
               state_d     = c_st_run;
               flush_cnt_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q + c_flush_cw'(1);
            end
         end
         default: state_d = c_st_run;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= c_st_run;
         word_count_q <= '0;
         load_err_q   <= 1'b0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
         load_err_q   <= load_err_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign word_count = word_count_q;
   assign load_err   = load_err_q;

`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if ((state_q == c_st_run) && load_req) begin
         checksum_d = '0;
      end else if (wr_accept) begin
         checksum_d = checksum_q ^ upg_dat_i;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
// ============================================================================
// tb_imem_load_ctrl : randomized scoreboard bench for imem_load_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_imem_load_ctrl;

   typedef struct packed {logic [14:0] adr; logic [31:0] dat;} wr_t;
   typedef struct packed {logic [13:0] a;   logic [31:0] d;}   ewr_t;
   typedef struct packed {logic [13:0] wc;  logic err; logic [31:0] cs;} res_t;

   logic        clock = 1'b0;
   logic        reset, load_req, upg_wen_i, upg_done_i;
   logic [14:0] upg_adr_i;
   logic [31:0] upg_dat_i, rom_douta;
   logic [13:0] fetch_addr;
   logic [31:0] fetch_dout, rom_dina, checksum;
   logic        rom_wea, cpu_stall, cpu_rst_o, upg_rst_o, load_err;
   logic [13:0] rom_addra, word_count;

   imem_load_ctrl dut (
      .clock(clock), .reset(reset), .load_req(load_req),
      .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i),
      .upg_done_i(upg_done_i), .fetch_addr(fetch_addr), .fetch_dout(fetch_dout),
      .rom_wea(rom_wea), .rom_addra(rom_addra), .rom_dina(rom_dina),
      .rom_douta(rom_douta), .cpu_stall(cpu_stall), .cpu_rst_o(cpu_rst_o),
      .upg_rst_o(upg_rst_o), .word_count(word_count), .load_err(load_err),
      .checksum(checksum)
   );

   always #5 clock = ~clock;

   int   checks = 0;
   int   errors = 0;
   wr_t  stim_q[$];
   ewr_t exp_wr_q[$];
   res_t exp_res_q[$];
   res_t last_res = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every ROM write and every end-of-load must match the scoreboard.
   logic prev_stall = 1'b0;
   logic prev_crst  = 1'b0;
   ewr_t mon_w;
   res_t mon_r;
   always @(negedge clock) begin
      if (rom_wea === 1'b1) begin
         if (exp_wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr 0x%04h data 0x%08h with no write expected", rom_addra, rom_dina);
         end else begin
            mon_w = exp_wr_q.pop_front();
            chk("wr_addr", 32'(rom_addra), 32'(mon_w.a));
            chk("wr_data", rom_dina, mon_w.d);
         end
      end
      if (prev_stall === 1'b1 && prev_crst === 1'b1 && cpu_stall === 1'b0) begin
         if (exp_res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: load ended with no result expected");
         end else begin
            mon_r = exp_res_q.pop_front();
            chk("res_word_count", 32'(word_count), 32'(mon_r.wc));
            chk("res_load_err", 32'(load_err), 32'(mon_r.err));
            chk("res_checksum", checksum, mon_r.cs);
         end
      end
      prev_stall <= cpu_stall;
      prev_crst  <= cpu_rst_o;
   end

   task automatic gen_rand(input int n);
      wr_t w;
      for (int i = 0; i < n; i++) begin
         w.adr     = 15'($urandom);
         w.adr[14] = ($urandom_range(0, 3) == 0);
         w.dat     = $urandom;
         stim_q.push_back(w);
      end
   endtask

   task automatic push_wr(input logic [14:0] adr, input logic [31:0] dat);
      wr_t w;
      w.adr = adr;
      w.dat = dat;
      stim_q.push_back(w);
   endtask

   task automatic run_fetch(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         fetch_addr = 14'($urandom);
         rom_douta  = $urandom;
         upg_wen_i  = 1'($urandom_range(0, 1));
         upg_adr_i  = 15'($urandom);
         upg_dat_i  = $urandom;
         @(negedge clock);
         chk("run_rom_addra", 32'(rom_addra), 32'(fetch_addr));
         chk("run_fetch_dout", fetch_dout, rom_douta);
         chk("run_rom_dina", rom_dina, 32'h0);
         chk("run_stall", 32'(cpu_stall), 32'h0);
         chk("run_upg_rst", 32'(upg_rst_o), 32'h1);
         chk("held_word_count", 32'(word_count), 32'(last_res.wc));
         chk("held_load_err", 32'(load_err), 32'(last_res.err));
         chk("held_checksum", checksum, last_res.cs);
      end
      upg_wen_i = 1'b0;
   endtask

   // Reference: the loader accepts every in-range write issued between the
   // request and done; count saturates, checksum is XOR of accepted data.
   task automatic run_session(input bit merge_done, input bit gaps, input bit noise);
      int          cnt;
      logic [31:0] cs;
      wr_t         w;
      ewr_t        e;
      res_t        r;
      bit          last;
      int          lat, pulses, crst_at;
      cnt = 0;
      cs  = '0;
      @(posedge clock); #1;
      load_req  = 1'b1;
      upg_wen_i = 1'b0;
      @(posedge clock); #1;
      load_req  = 1'b0;
      upg_wen_i = 1'b1;
      upg_adr_i = 15'($urandom) & 15'h3FFF;
      upg_dat_i = $urandom;
      @(negedge clock);
      chk("arm_stall", 32'(cpu_stall), 32'h1);
      chk("arm_upg_rst", 32'(upg_rst_o), 32'h0);
      chk("arm_clear_wc", 32'(word_count), 32'h0);
      chk("arm_clear_err", 32'(load_err), 32'h0);
      chk("arm_clear_cs", checksum, 32'h0);
      while (stim_q.size() > 0) begin
         w    = stim_q.pop_front();
         last = (stim_q.size() == 0);
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clock); #1;
               upg_wen_i = 1'b0;
               load_req  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
               upg_adr_i = 15'($urandom);
            end
         end
         @(posedge clock); #1;
         load_req   = 1'b0;
         upg_wen_i  = 1'b1;
         upg_adr_i  = w.adr;
         upg_dat_i  = w.dat;
         upg_done_i = merge_done && last;
         if (!w.adr[14]) begin
            e.a = w.adr[13:0];
            e.d = w.dat;
            exp_wr_q.push_back(e);
            if (cnt < 16383) cnt++;
            cs ^= w.dat;
         end
      end
      if (upg_done_i !== 1'b1) begin
         @(posedge clock); #1;
         upg_wen_i  = 1'b0;
         load_req   = 1'b0;
         upg_done_i = 1'b1;
      end
      r.wc  = 14'(cnt);
      r.err = (cnt == 0);
`ifdef IMEM_LOAD_CHECKSUM_EN
      r.cs  = cs;
`else
      r.cs  = '0;
`endif
      exp_res_q.push_back(r);
      last_res = r;
      @(negedge clock);
      chk("done_cycle_stall", 32'(cpu_stall), 32'h1);
      @(posedge clock); #1;
      upg_done_i = 1'b0;
      upg_wen_i  = 1'b0;
      lat = 0; pulses = 0; crst_at = 0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clock);
         if (cpu_rst_o === 1'b1) begin
            pulses++;
            crst_at = n;
         end
         if (cpu_stall === 1'b0 && lat == 0) lat = n;
         if (n == 1) chk("flush_upg_rst", 32'(upg_rst_o), 32'h1);
      end
      chk("done_to_run_cycles", 32'(lat), 32'd3);
      chk("cpu_rst_pulses", 32'(pulses), 32'd1);
      chk("cpu_rst_cycle", 32'(crst_at), 32'd2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; load_req = 1'b0; upg_wen_i = 1'b0; upg_done_i = 1'b0;
      upg_adr_i = '0; upg_dat_i = '0;
      fetch_addr = 14'h0010; rom_douta = 32'h2008_0005;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_fetch_dout", fetch_dout, 32'h2008_0005);
      chk("rst_rom_addra", 32'(rom_addra), 32'h0010);
      chk("rst_rom_wea", 32'(rom_wea), 32'h0);
      chk("rst_cpu_stall", 32'(cpu_stall), 32'h0);
      chk("rst_cpu_rst", 32'(cpu_rst_o), 32'h0);
      chk("rst_upg_rst", 32'(upg_rst_o), 32'h1);
      chk("rst_word_count", 32'(word_count), 32'h0);
      chk("rst_load_err", 32'(load_err), 32'h0);
      chk("rst_checksum", checksum, 32'h0);
      run_fetch(4);

      push_wr(15'h0000, 32'h1111_1111);
      push_wr(15'h0001, 32'h2222_2222);
      push_wr(15'h0002, 32'h4444_4444);
      run_session(1'b0, 1'b0, 1'b0);
      run_fetch(3);

      push_wr(15'h0003, 32'hCAFE_0003);
      push_wr(15'h4005, 32'hDEAD_4005);
      push_wr(15'h0004, 32'hCAFE_0004);
      run_session(1'b1, 1'b0, 1'b0);
      run_fetch(2);

      run_session(1'b0, 1'b0, 1'b0);
      run_fetch(4);

      push_wr(15'h0007, 32'h0BAD_F00D);
      run_session(1'b1, 1'b0, 1'b0);
      run_fetch(2);

      for (int s = 0; s < 8; s++) begin
         gen_rand($urandom_range(0, 12));
         run_session(1'($urandom_range(0, 1)), 1'b1, 1'b1);
         run_fetch(2);
      end

      for (int i = 0; i < 16390; i++) begin
         push_wr(15'(i) & 15'h3FFF, $urandom);
      end
      run_session(1'b1, 1'b0, 1'b0);
      run_fetch(2);

      // Reset in the middle of a load after two writes.
      @(posedge clock); #1 load_req = 1'b1;
      @(posedge clock); #1 load_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clock); #1;
         upg_wen_i = 1'b1;
         upg_adr_i = 15'(i + 8);
         upg_dat_i = $urandom;
         exp_wr_q.push_back({14'(i + 8), upg_dat_i});
      end
      @(posedge clock); #1;
      upg_wen_i = 1'b0;
      reset     = 1'b1;
      @(posedge clock); #1;
      reset     = 1'b0;
      upg_wen_i = 1'b1;
      upg_adr_i = 15'h0005;
      @(negedge clock);
      chk("mid_rst_stall", 32'(cpu_stall), 32'h0);
      chk("mid_rst_wea", 32'(rom_wea), 32'h0);
      chk("mid_rst_word_count", 32'(word_count), 32'h0);
      chk("mid_rst_upg_rst", 32'(upg_rst_o), 32'h1);
      chk("mid_rst_checksum", checksum, 32'h0);
      upg_wen_i = 1'b0;
      last_res  = '0;
      run_fetch(3);

      checks++;
      if (exp_wr_q.size() != 0) begin
         errors++;
         $display("FAIL pending_writes: %0d expected writes never seen, required 0", exp_wr_q.size());
      end
      checks++;
      if (exp_res_q.size() != 0) begin
         errors++;
         $display("FAIL pending_results: %0d load results never seen, required 0", exp_res_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have port clock, input, 1: single system clock; all state updates on posedge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port load_req, input, 1: one-cycle request to enter UART program-load mode.
REQ-004 SHALL have ports upg_wen_i (1), upg_adr_i (15), upg_dat_i (32), upg_done_i (1), all inputs: UART programmer write strobe, address, data and finished flag, synchronous to clock.
REQ-005 SHALL have ports fetch_addr (14, input) and fetch_dout (32, output): CPU fetch word address and the returned instruction.
REQ-006 SHALL have ports rom_wea (1), rom_addra (14), rom_dina (32), all outputs, and rom_douta (32, input): the single program-ROM port.
REQ-007 SHALL have outputs cpu_stall (1), cpu_rst_o (1), upg_rst_o (1), word_count (14), load_err (1), checksum (32).

Function
REQ-008 SHALL implement FSM RUN, ARM, LOAD, FLUSH; reset state RUN.
REQ-009 RUN: rom_addra=fetch_addr, rom_wea=0, rom_dina=0, fetch_dout=rom_douta, cpu_stall=0, upg_rst_o=1.
REQ-010 RUN with load_req=1 SHALL go to ARM next cycle, clearing word_count, load_err and checksum on that edge.
REQ-011 ARM SHALL last exactly 1 cycle (drains the in-flight fetch), cpu_stall=1, upg_rst_o=0, rom_wea=0, then go to LOAD.
REQ-012 LOAD: cpu_stall=1, upg_rst_o=0, fetch_dout=0; rom_addra=upg_adr_i[13:0], rom_dina=upg_dat_i, rom_wea=upg_wen_i & ~upg_adr_i[14], combinationally.
REQ-013 Each LOAD cycle with rom_wea=1 SHALL increment word_count, saturating at 16383; writes with upg_adr_i[14]=1 are dropped and not counted.
REQ-014 LOAD with upg_done_i=1 SHALL go to FLUSH; a write in the same cycle is performed and counted.
REQ-015 upg_done_i while word_count=0 (after same-cycle count) SHALL set load_err, sticky until next accepted load_req or reset.
REQ-016 FLUSH SHALL last exactly 2 cycles, cpu_stall=1, rom_wea=0, upg_rst_o=1; cpu_rst_o=1 on the second FLUSH cycle only, then RUN.
REQ-017 load_req outside RUN SHALL be ignored; upg_wen_i outside LOAD SHALL never reach rom_wea.
REQ-018 Latency load_req to first possible ROM write: 2 cycles; upg_done_i to cpu_stall=0: 3 cycles.

Reset
REQ-019 reset=1 at a clock edge SHALL force RUN from any state, including mid-LOAD; next cycle rom_wea=0.
REQ-020 Reset values: cpu_stall=0, cpu_rst_o=0, upg_rst_o=1, word_count=0, load_err=0, checksum=0, FLUSH counter=0.

Configuration
REQ-021 With IMEM_LOAD_CHECKSUM_EN defined, checksum SHALL update on each counted write as checksum<=checksum ^ upg_dat_i (32-bit XOR), cleared per REQ-010.
REQ-022 Without IMEM_LOAD_CHECKSUM_EN, checksum SHALL be constant 0 and no checksum register synthesised.

Structure
REQ-023 State encodings (RUN=2'd0, ARM=2'd1, LOAD=2'd2, FLUSH=2'd3), FLUSH length 2, ROM address width 14 and word_count max SHALL live in the shared defines include.
REQ-024 Implementation SHALL be one module; no sub-module, ROM instantiated outside.

Verification
REQ-025 Reset, fetch_addr=0x0010, rom_douta=0x2008_0005 -> fetch_dout=0x2008_0005, cpu_stall=0, rom_wea=0.
REQ-026 load_req; 3 writes adr 0x0000..0x0002 data 0x1111_1111, 0x2222_2222, 0x4444_4444; then upg_done_i -> word_count=3, checksum=0x7777_7777 (macro on), cpu_rst_o pulse 1 cycle, RUN 3 cycles after done.
REQ-027 In LOAD, write adr 0x4005 -> rom_wea=0, word_count unchanged.
REQ-028 load_req then upg_done_i with no writes -> load_err=1 held in RUN; next load_req clears it.
REQ-029 reset asserted during LOAD after 2 writes -> RUN next cycle, rom_wea=0, word_count=0, upg_rst_o=1.
REQ-030 upg_wen_i=1 and upg_done_i=1 same LOAD cycle, adr 0x0007 -> write performed, word_count+1, then FLUSH.
